jtag_dr_bank: RTL and testbench
===============================

Name: jtag_dr_bank

Overview:
- Parametrised next-generation JTAG data-register block: BYPASS, IDCODE, a STATUS register and NUM_USR user registers, each USR_W bits wide.
- Each user register is either read-write (RW: shifted value is committed at UPDATE_DR) or read-only (RO: captures live system data).
- Adds shift-length checking with a sticky error flag, per-register update pulses and a TDO output-enable.
- Sits between the TAP controller FSM/IR decoder and the system (AXI bridge, reset control) in the tck domain.

Parameters:
- NUM_USR, 4, number of user data registers (1..13).
- USR_W, 32, width of every user register (1..64).
- IDCODE_VAL, 32'h0000_010F, IDCODE capture value; bit0 must be 1.
- RO_MASK, '0 (NUM_USR bits), bit i=1 makes user register i read-only.
- USR_RST, '0 (NUM_USR*USR_W bits), reset/TLR value of the user registers.
- CHECK_LEN, 1, 1 = suppress an update when the shifted bit count is not equal to the register length.

Ports:
- tck  in  1  TAP clock; all state on rising edge except tdo/tdo_en.
- trst  in  1  synchronous active-high reset.
- tdi  in  1  serial input.
- tdo  out  1  serial output, changes on falling tck.
- tdo_en  out  1  high while shifting data.
- tap_state  in  tap_ctrl_fsm_t  current TAP FSM state (jtag_pkg).
- dr_sel  in  4  selected DR: 0 BYPASS, 1 IDCODE, 2 STATUS, 3+i user i; values ≥ 3+NUM_USR select BYPASS.
- usr_capture  in  NUM_USR*USR_W  capture data for RO registers.
- usr_q  out  NUM_USR*USR_W  committed RW register contents.
- usr_upd  out  NUM_USR  one-tck pulse per successful RW update.
- len_err  out  1  sticky shift-length error.

Behaviour:
- Reset: one clock, synchronous active-high reset (trst, sampled on rising tck; the falling-edge tdo flops also clear when trst is high).
  - usr_q=USR_RST; usr_upd=0; len_err=0; tdo=0; tdo_en=0.
  - Shift register, bit counter and update counter are cleared.
- Active length L: BYPASS 1, IDCODE 32, STATUS 8, user USR_W. One shared shift register sr of width max(32,USR_W); the bypass path uses sr[0].
- CAPTURE_DR loads sr[L-1:0] and clears the bit counter:
  - BYPASS: 0.
  - IDCODE: IDCODE_VAL.
  - STATUS: {upd_cnt[3:0], 3'b000, len_err}.
  - RW user i: usr_q[i].
  - RO user i: usr_capture[i].
- SHIFT_DR:
  - sr[L-1:0] <= {tdi, sr[L-1:1]}; bits above L-1 hold.
  - Bit counter increments and saturates at 127.
  - PAUSE_DR and EXIT states hold sr and the counter.
- Falling tck:
  - tdo <= (tap_state==SHIFT_DR) ? sr[0] : 0.
  - tdo_en <= (tap_state==SHIFT_DR).
- UPDATE_DR, with ok = !CHECK_LEN || cnt==L:
  - RW user i, ok: usr_q[i] <= sr[USR_W-1:0]; usr_upd[i]=1 for exactly the following tck cycle; upd_cnt increments and wraps 15→0.
  - RW user i, !ok: no write, no pulse; len_err <= 1.
  - RO user i: no write, no pulse, no error regardless of count.
  - STATUS, ok and sr[0]=1: len_err cleared (W1C). Other bits ignored. !ok sets len_err.
  - BYPASS/IDCODE: no effect.
- TEST_LOGIC_RESET state: same effect as trst, except that tdo/tdo_en follow the normal falling-edge rule.
- Capture of STATUS shows len_err as it stood before that capture.
- A second CAPTURE_DR without an intervening UPDATE_DR restarts the counter and discards the prior shift.
- dr_sel is sampled every cycle; it is only guaranteed stable from CAPTURE_DR through UPDATE_DR.
- trst during SHIFT_DR aborts the shift: no update, no pulse, no error.

Test Plan:
- Reset, then select IDCODE, capture, shift 32 bits -> tdo stream LSB-first equals 32'h0000_010F; tdo_en high for exactly 32 falling edges.
- Select BYPASS, shift 8 bits of tdi=1,0,1,1,0,0,1,0 -> tdo reproduces the sequence delayed by one bit, first bit 0.
- Select user 0 (RW, USR_W=32), shift 0xDEADBEEF, update -> usr_q[0]=0xDEADBEEF, usr_upd=4'b0001 for one cycle; STATUS capture reads upd_cnt=1, len_err=0.
- Select user 1, shift 31 bits, update -> usr_q[1] unchanged, no usr_upd, len_err=1; STATUS shift 8'h01 + update -> len_err=0; a 7-bit STATUS shift leaves len_err=1.
- RO user 2 (RO_MASK=4'b0100), usr_capture[2]=0x12345678, capture+shift 32 -> tdo reads 0x12345678; update -> no pulse, usr_q[2] stays USR_RST.
- 16 successful updates -> upd_cnt wraps to 0; entering TEST_LOGIC_RESET or asserting trst mid-shift -> usr_q=USR_RST, len_err=0, no usr_upd.

Source files
------------

// File: rtl/jtag_dr_bank_if.sv
// jtag_pkg: TAP controller state encoding shared by the TAP FSM and the DR bank.
// jtag_dr_bank_if: bundles the TAP-side and system-side signals of jtag_dr_bank.
//   master (TAP/system side): drives tdi, tap_state, dr_sel, usr_capture;
//                             observes tdo, tdo_en, usr_q, usr_upd, len_err.
//   slave  (DR bank):         the mirror image.
package jtag_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } tap_ctrl_fsm_t;
endpackage

interface jtag_dr_bank_if #(
  parameter int unsigned NUM_USR = 4,
  parameter int unsigned USR_W   = 32
);
  import jtag_pkg::*;

  logic                       tdi;
  logic                       tdo;
  logic                       tdo_en;
  tap_ctrl_fsm_t              tap_state;
  logic [3:0]                 dr_sel;
  logic [NUM_USR*USR_W-1:0]   usr_capture;
  logic [NUM_USR*USR_W-1:0]   usr_q;
  logic [NUM_USR-1:0]         usr_upd;
  logic                       len_err;

  modport master (
    output tdi, tap_state, dr_sel, usr_capture,
    input  tdo, tdo_en, usr_q, usr_upd, len_err
  );

  modport slave (
    input  tdi, tap_state, dr_sel, usr_capture,
    output tdo, tdo_en, usr_q, usr_upd, len_err
  );
endinterface

// File: rtl/jtag_dr_bank.sv
// jtag_dr_bank: JTAG data-register bank (BYPASS, IDCODE, STATUS, NUM_USR user
// registers) in the tck domain, with shift-length checking, a sticky length
// error, per-register update pulses and a TDO output enable.
//   tck   : TAP clock; state on rising edge, tdo/tdo_en on falling edge.
//   trst  : synchronous active-high reset.
//   bus   : jtag_dr_bank_if.slave (tdi, tap_state, dr_sel, usr_capture in;
//           tdo, tdo_en, usr_q, usr_upd, len_err out).
module jtag_dr_bank
  import jtag_pkg::*;
#(
  parameter int unsigned                 NUM_USR    = 4,
  parameter int unsigned                 USR_W      = 32,
  parameter logic [31:0]                 IDCODE_VAL = 32'h0000_010F,
  parameter logic [NUM_USR-1:0]          RO_MASK    = '0,
  parameter logic [NUM_USR*USR_W-1:0]    USR_RST    = '0,
  parameter int unsigned                 CHECK_LEN  = 1
) (
  input logic           tck,
  input logic           trst,
  jtag_dr_bank_if.slave bus
);

  localparam int unsigned SR_W = (USR_W > 32) ? USR_W : 32;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_STATUS,
    SEL_USER
  } sel_kind_t;

  logic [SR_W-1:0]    sr_q, sr_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [3:0]         upd_cnt_q, upd_cnt_d;
  logic               len_err_q, len_err_d;
  logic [USR_W-1:0]   usr_q_q [NUM_USR];
  logic [USR_W-1:0]   usr_d   [NUM_USR];
  logic [NUM_USR-1:0] usr_upd_q, usr_upd_d;
  logic               tdo_q, tdo_en_q;

  sel_kind_t          sel_kind;
  int unsigned        usr_idx;
  int unsigned        len;
  logic [SR_W-1:0]    cap;
  logic [SR_W-1:0]    sr_sh;
  logic               ok;

  // Out-of-range selections fall back to BYPASS.
  always_comb begin
    sel_kind = SEL_BYPASS;
    usr_idx  = 0;
    len      = 1;
    case (bus.dr_sel)
      4'd0: begin sel_kind = SEL_BYPASS; len = 1;  end
      4'd1: begin sel_kind = SEL_IDCODE; len = 32; end
      4'd2: begin sel_kind = SEL_STATUS; len = 8;  end
      default: begin
        if ({28'd0, bus.dr_sel} < NUM_USR + 32'd3) begin
          sel_kind = SEL_USER;
          usr_idx  = {28'd0, bus.dr_sel} - 32'd3;
          len      = USR_W;
        end
      end
    endcase
  end

  always_comb begin
    cap = '0;
    case (sel_kind)
      SEL_IDCODE: cap[31:0] = IDCODE_VAL;
      SEL_STATUS: cap[7:0]  = {upd_cnt_q, 3'b000, len_err_q};
      SEL_USER: begin
        for (int unsigned i = 0; i < NUM_USR; i++) begin
          if (usr_idx == i) begin
            cap[USR_W-1:0] = RO_MASK[i] ? bus.usr_capture[i*USR_W +: USR_W] : usr_q_q[i];
          end
        end
      end
      default: cap = '0;
    endcase
  end

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    upd_cnt_d = upd_cnt_q;
    len_err_d = len_err_q;
    usr_d     = usr_q_q;
    usr_upd_d = '0;
    sr_sh     = {1'b0, sr_q[SR_W-1:1]};
    ok        = (CHECK_LEN == 0) || ({25'd0, cnt_q} == len);
    case (bus.tap_state)
      CAPTURE_DR: begin
        for (int unsigned i = 0; i < SR_W; i++) begin
          if (i < len) sr_d[i] = cap[i];
        end
        cnt_d = '0;
      end
      SHIFT_DR: begin
        // Only the active window [len-1:0] moves; tdi enters at its top bit.
        for (int unsigned i = 0; i < SR_W; i++) begin
          if (i + 1 < len)       sr_d[i] = sr_sh[i];
          else if (i + 1 == len) sr_d[i] = bus.tdi;
        end
        if (cnt_q != 7'd127) cnt_d = cnt_q + 7'd1;
      end
      UPDATE_DR: begin
        case (sel_kind)
          SEL_USER: begin
            for (int unsigned i = 0; i < NUM_USR; i++) begin
              if (usr_idx == i && !RO_MASK[i]) begin
                if (ok) begin
                  usr_d[i]     = sr_q[USR_W-1:0];
                  usr_upd_d[i] = 1'b1;
                  upd_cnt_d    = upd_cnt_q + 4'd1;
                end else begin
                  len_err_d = 1'b1;
                end
              end
            end
          end
          SEL_STATUS: begin
            if (!ok)          len_err_d = 1'b1;
            else if (sr_q[0]) len_err_d = 1'b0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck) begin
    if (trst || bus.tap_state == TEST_LOGIC_RESET) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      upd_cnt_q <= '0;
      len_err_q <= 1'b0;
      usr_upd_q <= '0;
      for (int unsigned i = 0; i < NUM_USR; i++) begin
        usr_q_q[i] <= USR_RST[i*USR_W +: USR_W];
      end
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      upd_cnt_q <= upd_cnt_d;
      len_err_q <= len_err_d;
      usr_upd_q <= usr_upd_d;
      usr_q_q   <= usr_d;
    end
  end

  // TLR does not clear these; they follow the normal shift rule.
  always_ff @(negedge tck) begin
    if (trst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= (bus.tap_state == SHIFT_DR) ? sr_q[0] : 1'b0;
      tdo_en_q <= (bus.tap_state == SHIFT_DR);
    end
  end

  always_comb begin
    bus.usr_q = '0;
    for (int unsigned i = 0; i < NUM_USR; i++) begin
      bus.usr_q[i*USR_W +: USR_W] = usr_q_q[i];
    end
  end

  assign bus.usr_upd = usr_upd_q;
  assign bus.len_err = len_err_q;
  assign bus.tdo     = tdo_q;
  assign bus.tdo_en  = tdo_en_q;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Self-checking bench for jtag_dr_bank: a queue-based model of the active DR
// window predicts tdo/tdo_en at every falling edge and usr_q/usr_upd/len_err
// after every rising edge; directed literal checks pin the model.
module tb_jtag_dr_bank;
  import jtag_pkg::*;

  localparam int unsigned NUM_USR = 4;
  localparam int unsigned USR_W   = 32;
  localparam logic [NUM_USR-1:0]       RO_MASK = 4'b0100;
  localparam logic [NUM_USR*USR_W-1:0] USR_RST =
    128'h4444_4444_3333_3333_2222_2222_1111_1111;

  logic tck = 1'b0;
  logic trst;

  jtag_dr_bank_if #(.NUM_USR(NUM_USR), .USR_W(USR_W)) bus ();

  jtag_dr_bank #(
    .NUM_USR    (NUM_USR),
    .USR_W      (USR_W),
    .IDCODE_VAL (32'h0000_010F),
    .RO_MASK    (RO_MASK),
    .USR_RST    (USR_RST),
    .CHECK_LEN  (1)
  ) dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus)
  );

  always #5 tck = ~tck;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [USR_W-1:0]   m_usr [NUM_USR];
  logic               m_len_err;
  int                 m_upd_cnt;
  int                 m_cnt;
  bit                 q[$];
  logic [NUM_USR-1:0] m_upd;

  logic               last_tdo;
  int                 en_cnt;
  logic [NUM_USR-1:0] upd_after;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int dr_len(input int sel);
    if (sel == 0) return 1;
    if (sel == 1) return 32;
    if (sel == 2) return 8;
    if (sel < 3 + NUM_USR) return USR_W;
    return 1;
  endfunction

  function automatic logic [127:0] model_usr_q();
    logic [127:0] v = '0;
    for (int i = 0; i < NUM_USR; i++) v[i*USR_W +: USR_W] = m_usr[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_USR; i++) m_usr[i] = USR_RST[i*USR_W +: USR_W];
    m_len_err = 1'b0;
    m_upd_cnt = 0;
    m_cnt     = 0;
    q.delete();
  endtask

  task automatic model_edge(input tap_ctrl_fsm_t st, input logic t);
    int sel;
    int l;
    logic [63:0] capv;
    logic [USR_W-1:0] v;
    bit rw;
    m_upd = '0;
    if (trst || st == TEST_LOGIC_RESET) begin
      model_reset();
      return;
    end
    sel = int'(bus.dr_sel);
    l   = dr_len(sel);
    rw  = (sel >= 3 && sel < 3 + NUM_USR) ? !RO_MASK[sel-3] : 1'b0;
    case (st)
      CAPTURE_DR: begin
        capv = '0;
        if (sel == 1) capv[31:0] = 32'h0000_010F;
        else if (sel == 2) capv[7:0] = {m_upd_cnt[3:0], 3'b000, m_len_err};
        else if (sel >= 3 && sel < 3 + NUM_USR)
          capv[USR_W-1:0] = rw ? m_usr[sel-3] : bus.usr_capture[(sel-3)*USR_W +: USR_W];
        q.delete();
        for (int i = 0; i < l; i++) q.push_back(capv[i]);
        m_cnt = 0;
      end
      SHIFT_DR: begin
        void'(q.pop_front());
        q.push_back(t);
        m_cnt = (m_cnt < 127) ? m_cnt + 1 : 127;
      end
      UPDATE_DR: begin
        if (sel == 2) begin
          if (m_cnt != l) m_len_err = 1'b1;
          else if (q[0]) m_len_err = 1'b0;
        end else if (rw) begin
          if (m_cnt == l) begin
            for (int i = 0; i < USR_W; i++) v[i] = q[i];
            m_usr[sel-3]  = v;
            m_upd[sel-3]  = 1'b1;
            m_upd_cnt     = (m_upd_cnt + 1) % 16;
          end else begin
            m_len_err = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endtask

  // One TAP cycle: inputs applied after a rising edge, outputs compared
  // after the falling edge (tdo path) and after the next rising edge.
  task automatic step(input tap_ctrl_fsm_t st, input logic t);
    logic exp_en, exp_tdo;
    bus.tap_state = st;
    bus.tdi       = t;
    @(negedge tck); #1;
    exp_en  = !trst && st == SHIFT_DR;
    exp_tdo = (exp_en && q.size() > 0) ? q[0] : 1'b0;
    chk("tdo", {127'd0, bus.tdo}, {127'd0, exp_tdo});
    chk("tdo_en", {127'd0, bus.tdo_en}, {127'd0, exp_en});
    last_tdo = bus.tdo;
    if (bus.tdo_en) en_cnt++;
    @(posedge tck); #1;
    model_edge(st, t);
    chk("usr_q", bus.usr_q, model_usr_q());
    chk("usr_upd", {124'd0, bus.usr_upd}, {124'd0, m_upd});
    chk("len_err", {127'd0, bus.len_err}, {127'd0, m_len_err});
  endtask

  task automatic scan(input int sel, input int nbits, input logic [63:0] din,
                      input bit upd, input bit pause, input bit recap,
                      input int abort_at, output logic [63:0] dout);
    bus.dr_sel = sel[3:0];
    dout       = '0;
    upd_after  = '0;
    if (recap) begin
      step(CAPTURE_DR, 1'b0);
      for (int k = 0; k < 3; k++) step(SHIFT_DR, 1'($urandom));
      step(EXIT1_DR, 1'b0);
    end
    step(CAPTURE_DR, 1'($urandom));
    for (int k = 0; k < nbits; k++) begin
      if (k == abort_at) begin
        trst = 1'b1;
        step(SHIFT_DR, din[k % 64]);
        trst = 1'b0;
        step(RUN_TEST_IDLE, 1'b0);
        return;
      end
      step(SHIFT_DR, din[k % 64]);
      if (k < 64) dout[k] = last_tdo;
      if (pause && k == nbits / 2) begin
        step(EXIT1_DR, 1'b0);
        step(PAUSE_DR, 1'b1);
        step(PAUSE_DR, 1'b0);
        step(EXIT2_DR, 1'b1);
      end
    end
    step(EXIT1_DR, 1'b0);
    if (upd) begin
      step(UPDATE_DR, 1'b0);
      upd_after = bus.usr_upd;
    end
    step(RUN_TEST_IDLE, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int sel, l, nb;
    trst            = 1'b1;
    bus.tap_state   = RUN_TEST_IDLE;
    bus.tdi         = 1'b0;
    bus.dr_sel      = 4'd0;
    bus.usr_capture = {$urandom, $urandom, $urandom, $urandom};
    model_reset();
    m_upd = '0;
    repeat (2) @(posedge tck);
    #1;
    chk("rst_usr_q", bus.usr_q, USR_RST);
    chk("rst_usr_upd", {124'd0, bus.usr_upd}, 128'd0);
    chk("rst_len_err", {127'd0, bus.len_err}, 128'd0);
    chk("rst_tdo", {127'd0, bus.tdo}, 128'd0);
    chk("rst_tdo_en", {127'd0, bus.tdo_en}, 128'd0);
    trst = 1'b0;
    step(RUN_TEST_IDLE, 1'b0);

    // IDCODE
    en_cnt = 0;
    scan(1, 32, 64'd0, 1'b0, 1'b0, 1'b0, -1, d);
    chk("idcode", {96'd0, d[31:0]}, 128'h0000_010F);
    chk("idcode_en_cnt", 128'(en_cnt), 128'd32);

    // BYPASS: tdi 1,0,1,1,0,0,1,0 -> tdo 0,1,0,1,1,0,0,1
    scan(0, 8, 64'h4D, 1'b0, 1'b0, 1'b0, -1, d);
    chk("bypass", {120'd0, d[7:0]}, 128'h9A);

    // RW user 0
    scan(3, 32, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, -1, d);
    chk("usr0_pulse", {124'd0, upd_after}, 128'h1);
    chk("usr0_q", {96'd0, bus.usr_q[31:0]}, 128'hDEAD_BEEF);
    scan(2, 8, 64'd0, 1'b0, 1'b0, 1'b0, -1, d);
    chk("status_after_upd", {120'd0, d[7:0]}, 128'h10);

    // Short shift on user 1
    scan(4, 31, 64'h0123_4567, 1'b1, 1'b0, 1'b0, -1, d);
    chk("usr1_short_pulse", {124'd0, upd_after}, 128'h0);
    chk("usr1_short_err", {127'd0, bus.len_err}, 128'h1);
    chk("usr1_short_q", {96'd0, bus.usr_q[63:32]}, 128'h2222_2222);
    scan(2, 8, 64'h01, 1'b1, 1'b0, 1'b0, -1, d);
    chk("status_w1c", {127'd0, bus.len_err}, 128'h0);
    scan(4, 31, 64'h0, 1'b1, 1'b0, 1'b0, -1, d);
    scan(2, 7, 64'h7F, 1'b1, 1'b0, 1'b0, -1, d);
    chk("status_short", {127'd0, bus.len_err}, 128'h1);

    // RO user 2
    bus.usr_capture[95:64] = 32'h1234_5678;
    scan(5, 32, 64'hFFFF_0000, 1'b1, 1'b1, 1'b0, -1, d);
    chk("ro_read", {96'd0, d[31:0]}, 128'h1234_5678);
    chk("ro_pulse", {124'd0, upd_after}, 128'h0);
    chk("ro_q", {96'd0, bus.usr_q[95:64]}, 128'h3333_3333);

    // 15 more successful updates: counter wraps to 0
    for (int n = 0; n < 15; n++)
      scan(6, 32, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, -1, d);
    scan(2, 8, 64'd0, 1'b0, 1'b0, 1'b0, -1, d);
    chk("status_wrap", {120'd0, d[7:0]}, 128'h01);

    // TEST_LOGIC_RESET
    step(TEST_LOGIC_RESET, 1'b0);
    chk("tlr_usr_q", bus.usr_q, USR_RST);
    chk("tlr_len_err", {127'd0, bus.len_err}, 128'h0);
    step(RUN_TEST_IDLE, 1'b0);

    // trst mid-shift
    scan(3, 32, 64'hCAFE_F00D, 1'b1, 1'b0, 1'b0, -1, d);
    scan(4, 31, 64'h0, 1'b1, 1'b0, 1'b0, -1, d);
    scan(3, 32, 64'h5555_AAAA, 1'b1, 1'b0, 1'b0, 10, d);
    chk("trst_usr_q", bus.usr_q, USR_RST);
    chk("trst_usr_upd", {124'd0, bus.usr_upd}, 128'h0);
    chk("trst_len_err", {127'd0, bus.len_err}, 128'h0);

    // Counter saturation: 130 shifts is not 32
    scan(3, 130, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, -1, d);
    chk("sat_err", {127'd0, bus.len_err}, 128'h1);

    // Randomized transactions
    for (int n = 0; n < 300; n++) begin
      bus.usr_capture = {$urandom, $urandom, $urandom, $urandom};
      sel = int'($urandom_range(0, 8));
      l   = dr_len(sel);
      case ($urandom_range(0, 5))
        0: nb = l - 1;
        1: nb = l + 1;
        2: nb = int'($urandom_range(0, 40));
        default: nb = l;
      endcase
      if (nb < 0) nb = 0;
      if (sel == 2 && $urandom_range(0, 1) == 1) nb = 8;
      scan(sel, nb, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
           ($urandom_range(0, 19) == 0 && nb > 0) ? int'($urandom_range(0, nb - 1)) : -1, d);
      if ($urandom_range(0, 29) == 0) begin
        step(TEST_LOGIC_RESET, 1'b0);
        step(RUN_TEST_IDLE, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
